// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the 16-bit pipeline: owns the PC, captures memory words into IF/ID,
// and handles stalls, downstream redirects with squash, and HALT freezing.
module instruction_fetch_stage #(
  parameter int                   DataWidth  = 16,
  parameter logic [DataWidth-1:0] ResetPC    = 16'h0000,
  parameter logic [3:0]           HaltOpcode = 4'hF,
  parameter logic [DataWidth-1:0] NopInstr   = 16'h0000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Stall,
  input  logic                 Redirect,
  input  logic [DataWidth-1:0] RedirectPC,
  input  logic [DataWidth-1:0] Instruction,
  output logic [DataWidth-1:0] CurrentPC,
  output logic [DataWidth-1:0] IF_ID_Instr,
  output logic [DataWidth-1:0] IF_ID_PC,
  output logic                 IF_ID_Valid,
  output logic                 Halted,
  output logic [15:0]          FetchCount
);

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [DataWidth-1:0] PcOne  = {{(DataWidth-1){1'b0}}, 1'b1};
  localparam logic [DataWidth-1:0] PcZero = {DataWidth{1'b0}};

  state_t               state_r, state_s;
  logic [DataWidth-1:0] pc_r, pc_s;
  logic [DataWidth-1:0] instr_r, instr_s;
  logic [DataWidth-1:0] ipc_r, ipc_s;
  logic                 valid_r, valid_s;
  logic                 halted_r, halted_s;
  logic [15:0]          count_r, count_s;
  logic [DataWidth-1:0] pc_inc_s;
  logic                 is_halt_s;

  assign pc_inc_s  = pc_r + PcOne;
  assign is_halt_s = (Instruction[DataWidth-1 -: 4] == HaltOpcode);

  // Next-state and IF/ID contents; redirect outranks stall, stall outranks the state action.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    ipc_s   = ipc_r;
    valid_s = valid_r;
    count_s = count_r;
    if (Redirect) begin
      state_s = FETCH;
      pc_s    = RedirectPC;
      instr_s = NopInstr;
      ipc_s   = PcZero;
      valid_s = 1'b0;
    end else if (Stall) begin
      state_s = state_r;
    end else begin
      case (state_r)
        FETCH: begin
          instr_s = Instruction;
          ipc_s   = pc_inc_s;
          valid_s = 1'b1;
          count_s = count_r + 16'd1;
          if (is_halt_s) begin
            state_s = HALTED;
          end else begin
            pc_s = pc_inc_s;
          end
        end
        HALTED: begin
          instr_s = NopInstr;
          ipc_s   = PcZero;
          valid_s = 1'b0;
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end
    halted_s = (state_s == HALTED);
  end

  // PC, IF/ID register, state and fetch counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= FETCH;
      pc_r     <= ResetPC;
      instr_r  <= NopInstr;
      ipc_r    <= PcZero;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      count_r  <= 16'd0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      instr_r  <= instr_s;
      ipc_r    <= ipc_s;
      valid_r  <= valid_s;
      halted_r <= halted_s;
      count_r  <= count_s;
    end
  end

  assign CurrentPC   = pc_r;
  assign IF_ID_Instr = instr_r;
  assign IF_ID_PC    = ipc_r;
  assign IF_ID_Valid = valid_r;
  assign Halted      = halted_r;
  assign FetchCount  = count_r;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed program scenarios followed by a
// randomized stall/redirect stream, all checked against an architectural model.
module tb_instruction_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectPC = 16'h0000;
  logic [15:0] Instruction;
  logic [15:0] CurrentPC, IF_ID_Instr, IF_ID_PC, FetchCount;
  logic        IF_ID_Valid, Halted;

  logic [15:0] mem [0:65535];
  int total = 0;
  int bad = 0;

  // architectural model of the fetch stage
  logic [15:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_valid, m_halted;

  instruction_fetch_stage dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .Instruction(Instruction),
    .CurrentPC(CurrentPC), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC(IF_ID_PC),
    .IF_ID_Valid(IF_ID_Valid), .Halted(Halted), .FetchCount(FetchCount)
  );

  always #5 CLK = ~CLK;
  assign Instruction = mem[CurrentPC];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":pc"},     CurrentPC, m_pc);
    chk({ctx, ":instr"},  IF_ID_Instr, m_instr);
    chk({ctx, ":ipc"},    IF_ID_PC, m_ipc);
    chk({ctx, ":valid"},  {15'd0, IF_ID_Valid}, {15'd0, m_valid});
    chk({ctx, ":halted"}, {15'd0, Halted}, {15'd0, m_halted});
    chk({ctx, ":count"},  FetchCount, m_count);
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
  endtask

  // One clock edge of the architectural behaviour for the given inputs.
  task automatic model_edge(input logic s, input logic r, input logic [15:0] rpc);
    logic [15:0] w;
    if (r) begin
      m_pc = rpc; m_instr = 16'h0000; m_ipc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (!s) begin
      if (m_halted) begin
        m_instr = 16'h0000; m_ipc = 16'h0000; m_valid = 1'b0;
      end else begin
        w = mem[m_pc];
        m_instr = w; m_ipc = m_pc + 16'd1; m_valid = 1'b1; m_count = m_count + 16'd1;
        if (w[15:12] == 4'hF) m_halted = 1'b1;
        else m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic step(input string ctx, input logic s, input logic r, input logic [15:0] rpc);
    Stall = s; Redirect = r; RedirectPC = rpc;
    model_edge(s, r, rpc);
    @(posedge CLK);
    #1;
    check_all(ctx);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i % 4096);
    mem[0] = 16'h1502; mem[1] = 16'h2655; mem[2] = 16'h2765; mem[3] = 16'hF000;
    mem[16'hFFFF] = 16'h1234;
    model_reset();

    // reset state
    @(posedge CLK); @(posedge CLK); #1;
    check_all("reset");
    RST = 1'b1;

    // first fetch, then stall two cycles at PC=1, then resume
    step("run0", 1'b0, 1'b0, 16'h0000);
    chk("run0_word", IF_ID_Instr, 16'h1502);
    step("stall1", 1'b1, 1'b0, 16'h0000);
    step("stall2", 1'b1, 1'b0, 16'h0000);
    chk("stall_pc", CurrentPC, 16'h0001);
    step("resume", 1'b0, 1'b0, 16'h0000);
    chk("resume_word", IF_ID_Instr, 16'h2655);

    // redirect at PC=2 back to 0: bubble then 1502
    step("redir", 1'b0, 1'b1, 16'h0000);
    chk("redir_valid", {15'd0, IF_ID_Valid}, 16'h0000);
    step("redir_tgt", 1'b0, 1'b0, 16'h0000);
    chk("redir_word", IF_ID_Instr, 16'h1502);
    chk("redir_ipc", IF_ID_PC, 16'h0001);

    // run to HALT and stay there
    for (int i = 0; i < 6; i++) step("toward_halt", 1'b0, 1'b0, 16'h0000);
    chk("halt_pc", CurrentPC, 16'h0003);
    chk("halt_flag", {15'd0, Halted}, 16'h0001);

    // redirect out of HALTED to PC=1
    step("unhalt", 1'b0, 1'b1, 16'h0001);
    chk("unhalt_flag", {15'd0, Halted}, 16'h0000);
    step("unhalt_tgt", 1'b0, 1'b0, 16'h0000);
    chk("unhalt_word", IF_ID_Instr, 16'h2655);

    // simultaneous stall and redirect to 2
    step("stall_redir", 1'b1, 1'b1, 16'h0002);
    chk("sr_pc", CurrentPC, 16'h0002);
    step("sr_tgt", 1'b0, 1'b0, 16'h0000);
    chk("sr_word", IF_ID_Instr, 16'h2765);

    // PC wrap from FFFF
    step("to_ffff", 1'b0, 1'b1, 16'hFFFF);
    step("wrap", 1'b0, 1'b0, 16'h0000);
    chk("wrap_pc", CurrentPC, 16'h0000);
    chk("wrap_ipc", IF_ID_PC, 16'h0000);

    // asynchronous reset between edges
    #2 RST = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(posedge CLK); #1;
    check_all("rst_hold");
    RST = 1'b1;

    // random program and random stall/redirect stream
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      logic [15:0] rpc;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      step("rand", s, r, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
